// File: rtl/sgpio_tx_multi.sv
// SGPIO transmitter: serialises per-drive ACT/LOC/FLT status
// into CK/LD/DATA frames with a programmable divider and gap.
module sgpio_tx_multi #(
   parameter int NUM_DRV      = 36,
   parameter int BITS_PER_DRV = 3,
   parameter int CLK_DIV      = 50,
   parameter int GAP_CLKS     = 4
) (
   input  logic               SYSCLK,
   input  logic               RESET,
   input  logic               ENABLE,
   input  logic [NUM_DRV-1:0] DRV_ACT,
   input  logic [NUM_DRV-1:0] DRV_LOC,
   input  logic [NUM_DRV-1:0] DRV_FLT,
   output logic               SGPIO_CK,
   output logic               SGPIO_LD,
   output logic               SGPIO_DATA,
   output logic               BUSY,
   output logic               FRAME_DONE
);

   localparam int FB = NUM_DRV * BITS_PER_DRV;
   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = (FB > 1) ? $clog2(FB) : 1;
   localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

   state_t              state_q, state_d;
   logic [DW-1:0]       div_q, div_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic [FB:0]         shadow_q, shadow_d;
   logic [NUM_DRV-1:0]  act_stk_q, act_stk_d;
   logic                ck_q, ck_d;
   logic                ld_q, ld_d;
   logic                data_q, data_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                load;
   logic                tc;
   logic [FB-1:0]       snap;
   logic                unused_in;

   // Frame image: drive0 {ACT,LOC,FLT}, drive1, ... with sticky ACT folded in
   for (genvar g = 0; g < NUM_DRV; g++) begin : g_drv
      assign snap[g*BITS_PER_DRV] = act_stk_q[g] | DRV_ACT[g];
      if (BITS_PER_DRV > 1) begin : g_loc
         assign snap[g*BITS_PER_DRV+1] = DRV_LOC[g];
      end
      if (BITS_PER_DRV > 2) begin : g_flt
         assign snap[g*BITS_PER_DRV+2] = DRV_FLT[g];
      end
   end

   assign unused_in = ^{DRV_LOC, DRV_FLT};
   assign tc        = (div_q == DW'(CLK_DIV - 1));

   // Next-state, counters and registered output values
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bit_d    = bit_q;
      gap_d    = gap_q;
      shadow_d = shadow_q;
      ck_d     = ck_q;
      ld_d     = ld_q;
      data_d   = data_q;
      done_d   = 1'b0;
      load     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ENABLE) load = 1'b1;
         end
         LOAD: begin
            state_d = SHIFT;
            div_d   = '0;
         end
         SHIFT: begin
            div_d = tc ? '0 : div_q + 1'b1;
            if (tc) ck_d = ~ck_q;
            if (tc && ck_q) begin
               ld_d = 1'b0;
               if (bit_q == BW'(FB - 1)) begin
                  state_d = GAP;
                  data_d  = 1'b0;
                  bit_d   = '0;
                  gap_d   = '0;
               end else begin
                  bit_d    = bit_q + 1'b1;
                  data_d   = shadow_q[1];
                  shadow_d = shadow_q >> 1;
               end
            end
         end
         GAP: begin
            div_d = tc ? '0 : div_q + 1'b1;
            if (tc) ck_d = ~ck_q;
            done_d = ck_q && (div_q == DW'(CLK_DIV - 2))
                     && (gap_q == GW'(GAP_CLKS - 1));
            if (tc && ck_q) begin
               if (gap_q == GW'(GAP_CLKS - 1)) begin
                  if (ENABLE) load = 1'b1;
                  else        state_d = IDLE;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         state_d  = LOAD;
         shadow_d = {1'b0, snap};
         data_d   = snap[0];
         ld_d     = 1'b1;
         ck_d     = 1'b0;
         div_d    = '0;
         bit_d    = '0;
         gap_d    = '0;
      end
      act_stk_d = load ? DRV_ACT : (act_stk_q | DRV_ACT);
      busy_d    = (state_d != IDLE);
   end

   // State and output registers; reset aborts any frame in flight
   always_ff @(posedge SYSCLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= IDLE;
         div_q     <= '0;
         bit_q     <= '0;
         gap_q     <= '0;
         shadow_q  <= '0;
         act_stk_q <= '0;
         ck_q      <= 1'b0;
         ld_q      <= 1'b0;
         data_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         gap_q     <= gap_d;
         shadow_q  <= shadow_d;
         act_stk_q <= act_stk_d;
         ck_q      <= ck_d;
         ld_q      <= ld_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign SGPIO_CK   = ck_q;
   assign SGPIO_LD   = ld_q;
   assign SGPIO_DATA = data_q;
   assign BUSY       = busy_q;
   assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_sgpio_tx_multi.sv
// Directed bench for sgpio_tx_multi: a small 4-drive link and
// the 36-drive activity-only link, received on CK rising edges.
module tb_sgpio_tx_multi;

   logic        clk = 1'b0;
   logic        rst_a, en_a;
   logic [3:0]  act_a, loc_a, flt_a;
   logic        ck_a, ld_a, data_a, busy_a, done_a;
   logic        rst_b, en_b;
   logic [35:0] act_b, loc_b, flt_b;
   logic        ck_b, ld_b, data_b, busy_b, done_b;

   logic        sel;
   logic        ck_s, ld_s, data_s;
   logic        tmo;
   int          n_chk, n_pass;
   int          cyc;
   int          prev_t, last_t;
   logic [63:0] bits, lds;
   logic        d, l;
   int          act_cnt;

   always #5 clk = ~clk;

   sgpio_tx_multi #(
      .NUM_DRV(4), .BITS_PER_DRV(3), .CLK_DIV(2), .GAP_CLKS(2)
   ) u_a (
      .SYSCLK(clk), .RESET(rst_a), .ENABLE(en_a),
      .DRV_ACT(act_a), .DRV_LOC(loc_a), .DRV_FLT(flt_a),
      .SGPIO_CK(ck_a), .SGPIO_LD(ld_a), .SGPIO_DATA(data_a),
      .BUSY(busy_a), .FRAME_DONE(done_a)
   );

   sgpio_tx_multi #(
      .NUM_DRV(36), .BITS_PER_DRV(1), .CLK_DIV(50), .GAP_CLKS(4)
   ) u_b (
      .SYSCLK(clk), .RESET(rst_b), .ENABLE(en_b),
      .DRV_ACT(act_b), .DRV_LOC(loc_b), .DRV_FLT(flt_b),
      .SGPIO_CK(ck_b), .SGPIO_LD(ld_b), .SGPIO_DATA(data_b),
      .BUSY(busy_b), .FRAME_DONE(done_b)
   );

   always_comb begin
      ck_s   = sel ? ck_b   : ck_a;
      ld_s   = sel ? ld_b   : ld_a;
      data_s = sel ? data_b : data_a;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done_a) begin
         prev_t <= last_t;
         last_t <= cyc;
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic next_rise(output logic od, output logic ol);
      logic prev;
      int   n;
      prev = ck_s;
      n    = 0;
      od   = 1'b0;
      ol   = 1'b0;
      forever begin
         @(negedge clk);
         n++;
         if (ck_s && !prev) begin
            od = data_s;
            ol = ld_s;
            return;
         end
         prev = ck_s;
         if (n > 400) begin
            tmo = 1'b1;
            return;
         end
      end
   endtask

   task automatic recv(input int nb, input int drop_at,
                       output logic [63:0] ob, output logic [63:0] ol);
      logic rd, rl;
      int   k;
      ob = '0;
      ol = '0;
      k  = 0;
      do begin
         next_rise(rd, rl);
         k++;
      end while (!rl && k < 64 && !tmo);
      ob[0] = rd;
      ol[0] = rl;
      for (int i = 1; i < nb; i++) begin
         next_rise(rd, rl);
         ob[i] = rd;
         ol[i] = rl;
         if (i == drop_at) en_a = 1'b0;
      end
   endtask

   task automatic wait_done(input int lim);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done_a && n < lim);
      if (!done_a) tmo = 1'b1;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      cyc    = 0;
      prev_t = 0;
      last_t = 0;
      tmo    = 1'b0;
      sel    = 1'b0;
      rst_a  = 1'b1;
      en_a   = 1'b1;
      act_a  = 4'b0101;
      loc_a  = 4'b0010;
      flt_a  = 4'b1000;
      rst_b  = 1'b1;
      en_b   = 1'b1;
      act_b  = 36'hB_0000_0005;
      loc_b  = '0;
      flt_b  = '0;

      repeat (10) @(negedge clk);
      check("reset_outs", {ck_a, ld_a, data_a, busy_a, done_a}, 5'b0);
      rst_a = 1'b0;
      @(negedge clk);
      check("first_load", {ld_a, busy_a, ck_a, data_a}, 4'b1101);

      fork
         recv(12, -1, bits, lds);
         begin
            repeat (20) @(negedge clk);
            act_a = 4'b0001;
         end
      join
      check("f1_bits", bits[11:0], 12'h851);
      check("f1_ld", lds[11:0], 12'h001);

      recv(12, -1, bits, lds);
      check("f2_sticky", bits[11:0], 12'h851);
      check("f2_ld", lds[11:0], 12'h001);

      fork
         recv(12, -1, bits, lds);
         begin
            repeat (25) @(negedge clk);
            act_a[2] = 1'b1;
            loc_a    = 4'b0000;
            @(negedge clk);
            act_a[2] = 1'b0;
         end
      join
      check("f3_frozen", bits[11:0], 12'h811);
      check("period", last_t - prev_t, 57);

      recv(12, -1, bits, lds);
      check("f4_pulse", bits[11:0], 12'h841);

      recv(12, 5, bits, lds);
      check("f5_bits", bits[11:0], 12'h801);
      check("f5_ld", lds[11:0], 12'h001);
      wait_done(100);
      @(negedge clk);
      check("idle_outs", {ck_a, ld_a, data_a, busy_a, done_a}, 5'b0);
      act_cnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (ld_a || busy_a || ck_a) act_cnt++;
      end
      check("idle_quiet", act_cnt, 0);

      en_a = 1'b1;
      next_rise(d, l);
      for (int i = 1; i <= 7; i++) next_rise(d, l);
      check("busy_mid", {busy_a, ck_a}, 2'b11);
      #2 rst_a = 1'b1;
      #1 check("async_rst",
               {ck_a, ld_a, data_a, busy_a, done_a}, 5'b0);
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      recv(12, -1, bits, lds);
      check("rst_frame", bits[11:0], 12'h801);
      check("rst_ld", lds[11:0], 12'h001);

      sel = 1'b1;
      check("b_reset", {ck_b, ld_b, data_b, busy_b, done_b}, 5'b0);
      rst_b = 1'b0;
      recv(36, -1, bits, lds);
      check("b_bits", bits[35:0], 36'hB_0000_0005);
      check("b_ld", lds[35:0], 36'h1);

      check("no_timeout", tmo, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
